// File: rtl/mvm_pkg.sv
// Shared types and default sizing for the matrix-vector multiplier operand path.
package mvm_pkg;

  localparam int MVM_N          = 8;
  localparam int MVM_DATA_WIDTH = 32;
  localparam int MVM_FRAC_WIDTH = 16;

  typedef enum logic {
    KIND_J = 1'b0,
    KIND_X = 1'b1
  } frame_kind_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECV_J = 3'd1,
    ST_RECV_X = 3'd2,
    ST_DRAIN  = 3'd3,
    ST_ISSUE  = 3'd4
  } loader_state_e;

  // Counter must be able to hold the full J length (N*N), hence the +1.
  function automatic int cnt_width(input int n);
    return $clog2(n * n + 1);
  endfunction

  localparam int J_LEN = MVM_N * MVM_N;
  localparam int X_LEN = MVM_N;
  localparam int CNT_W = cnt_width(MVM_N);

endpackage

// File: rtl/mvm_operand_loader.sv
// Packs a serial valid/ready element stream into the J matrix and x vector
// registers and strobes mvm_valid when a fresh x arrives against a loaded J.
module mvm_operand_loader
  import mvm_pkg::*;
#(
  parameter int N          = MVM_N,
  parameter int DATA_WIDTH = MVM_DATA_WIDTH,
  parameter int FRAC_WIDTH = MVM_FRAC_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic [DATA_WIDTH-1:0]        s_data,
  input  logic                         s_kind,
  input  logic                         s_last,
  output logic [N*N*DATA_WIDTH-1:0]    j_out,
  output logic [N*DATA_WIDTH-1:0]      x_out,
  output logic                         mvm_valid,
  output logic                         j_loaded,
  output logic                         frame_err,
  output logic [2:0]                   state_dbg
);

  localparam int MAT_LEN  = N * N;
  localparam int VEC_LEN  = N;
  localparam int CNT_BITS = cnt_width(N);

  // The fixed-point format is carried through untouched; only sanity-check it.
  if (FRAC_WIDTH < 0 || FRAC_WIDTH >= DATA_WIDTH) begin : g_bad_frac
    $error("FRAC_WIDTH must lie in [0, DATA_WIDTH)");
  end

  // Stream handshake: a beat transfers on a rising clk edge where both
  // s_valid and s_ready are high; s_data/s_kind/s_last are qualified by s_valid.
  loader_state_e        state, state_n;
  frame_kind_e          kind_q, kind_n, cur_kind;
  logic [CNT_BITS-1:0]  cnt, cnt_n, idx, final_idx;
  logic                 j_loaded_n, frame_err_n;
  logic                 accept, wr_en;

  assign s_ready   = rst_n && (state != ST_ISSUE);
  assign accept    = s_valid && s_ready;
  assign mvm_valid = (state == ST_ISSUE);
  assign state_dbg = state;

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    kind_n      = kind_q;
    j_loaded_n  = j_loaded;
    frame_err_n = 1'b0;
    wr_en       = 1'b0;
    cur_kind    = (state == ST_IDLE) ? frame_kind_e'(s_kind) : kind_q;
    idx         = (state == ST_IDLE) ? '0 : cnt;
    final_idx   = (cur_kind == KIND_J) ? CNT_BITS'(MAT_LEN - 1) : CNT_BITS'(VEC_LEN - 1);

    case (state)
      ST_IDLE, ST_RECV_J, ST_RECV_X: begin
        if (accept) begin
          wr_en  = 1'b1;
          kind_n = cur_kind;
          // J is rewritten in place, so it stops being valid on the first beat.
          if (state == ST_IDLE && cur_kind == KIND_J) j_loaded_n = 1'b0;
          if (idx == final_idx) begin
            cnt_n = '0;
            if (s_last) begin
              if (cur_kind == KIND_J) begin
                j_loaded_n = 1'b1;
                state_n    = ST_IDLE;
              end else begin
                state_n = j_loaded ? ST_ISSUE : ST_IDLE;
              end
            end else begin
              frame_err_n = 1'b1;
              state_n     = ST_DRAIN;
              if (cur_kind == KIND_J) j_loaded_n = 1'b0;
            end
          end else if (s_last) begin
            frame_err_n = 1'b1;
            cnt_n       = '0;
            state_n     = ST_IDLE;
            if (cur_kind == KIND_J) j_loaded_n = 1'b0;
          end else begin
            cnt_n   = idx + 1'b1;
            state_n = (cur_kind == KIND_J) ? ST_RECV_J : ST_RECV_X;
          end
        end
      end
      ST_DRAIN: begin
        if (accept && s_last) state_n = ST_IDLE;
      end
      ST_ISSUE: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      kind_q    <= KIND_J;
      j_loaded  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      kind_q    <= kind_n;
      j_loaded  <= j_loaded_n;
      frame_err <= frame_err_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_out <= '0;
      x_out <= '0;
    end else if (wr_en) begin
      if (cur_kind == KIND_J) begin
        for (int e = 0; e < MAT_LEN; e++) begin
          if (idx == CNT_BITS'(e)) j_out[e*DATA_WIDTH +: DATA_WIDTH] <= s_data;
        end
      end else begin
        for (int e = 0; e < VEC_LEN; e++) begin
          if (idx == CNT_BITS'(e)) x_out[e*DATA_WIDTH +: DATA_WIDTH] <= s_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mvm_operand_loader.sv
// Directed bench for mvm_operand_loader at N=4 with Q16.16 elements.
module tb_mvm_operand_loader;
  import mvm_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam logic [DW-1:0] ONE = 32'h0001_0000;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                s_valid, s_ready, s_kind, s_last;
  logic [DW-1:0]       s_data;
  logic [N*N*DW-1:0]   j_out;
  logic [N*DW-1:0]     x_out;
  logic                mvm_valid, j_loaded, frame_err;
  logic [2:0]          state_dbg;

  mvm_operand_loader #(.N(N), .DATA_WIDTH(DW), .FRAC_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .s_kind(s_kind), .s_last(s_last),
    .j_out(j_out), .x_out(x_out),
    .mvm_valid(mvm_valid), .j_loaded(j_loaded), .frame_err(frame_err),
    .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state
  logic [N*DW-1:0]   exp_q[$];
  logic [N*N*DW-1:0] exp_j;
  logic [N*DW-1:0]   exp_x;
  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;

  task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Every mvm_valid strobe must match a queued x vector, against the modelled J.
  always @(negedge clk) begin
    if (rst_n && mvm_valid) begin
      if (exp_q.size() == 0) check_eq("mvm_unexpected", mvm_valid, 0);
      else begin
        check_eq("issue_x", x_out, exp_q.pop_front());
        check_eq("issue_j", j_out, exp_j);
      end
    end
    if (rst_n && frame_err) fe_cnt++;
  end

  // driver tasks: called one step after a rising edge, return one step after
  // the edge on which the beat was accepted
  task automatic send_beat(input logic [DW-1:0] data, input logic kind, input logic last);
    int waited;
    s_valid = 1'b1; s_data = data; s_kind = kind; s_last = last;
    waited = 0;
    while (!s_ready && waited < 16) begin
      @(posedge clk); #1; waited++;
    end
    if (!s_ready) check_eq("ready_timeout", s_ready, 1);
    else begin
      @(posedge clk); #1;
    end
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_x_frame(input logic [N*DW-1:0] vals);
    for (int k = 0; k < N; k++) begin
      exp_x[k*DW +: DW] = vals[k*DW +: DW];
      send_beat(vals[k*DW +: DW], 1'b1, k == N-1);
    end
  endtask

  task automatic send_j_frame(input bit ident, input logic [DW-1:0] base);
    logic [DW-1:0] v;
    for (int e = 0; e < N*N; e++) begin
      v = ident ? (((e / N) == (e % N)) ? ONE : '0) : base + DW'(e);
      exp_j[e*DW +: DW] = v;
      send_beat(v, 1'b0, e == N*N-1);
      if (e == N*N-2) check_eq("j_loaded_before_last", j_loaded, 0);
    end
  endtask

  int fe0;

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_kind = 1'b0; s_last = 1'b0;
    exp_j = '0; exp_x = '0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_s_ready", s_ready, 0);
    check_eq("rst_j_out", j_out, 0);
    check_eq("rst_x_out", x_out, 0);
    check_eq("rst_flags", {mvm_valid, j_loaded, frame_err}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_ready", s_ready, 1);
    check_eq("post_rst_state", state_dbg, ST_IDLE);

    // x frame with no J loaded: stored, never issued
    send_x_frame({32'd8, 32'd7, 32'd6, 32'd5});
    check_eq("xnoj_mvm", mvm_valid, 0);
    check_eq("xnoj_state", state_dbg, ST_IDLE);
    check_eq("xnoj_x_out", x_out, exp_x);
    check_eq("xnoj_fe", fe_cnt, 0);

    // identity J then x = {1,2,3,4}
    send_j_frame(1'b1, '0);
    check_eq("ident_j_loaded", j_loaded, 1);
    check_eq("ident_j_out", j_out, exp_j);
    exp_q.push_back({4*ONE, 3*ONE, 2*ONE, ONE});
    send_x_frame({4*ONE, 3*ONE, 2*ONE, ONE});
    check_eq("issue_mvm_valid", mvm_valid, 1);
    check_eq("issue_s_ready", s_ready, 0);
    check_eq("issue_x0", x_out[31:0], 32'h0001_0000);
    @(posedge clk); #1;
    check_eq("after_issue_mvm", mvm_valid, 0);
    check_eq("after_issue_ready", s_ready, 1);

    // second x frame against the same J, negative data passes through unchanged
    exp_q.push_back({32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 32'h7FFF_FFFF});
    send_x_frame({32'hFFFF_0000, 32'h0000_8000, 32'h8000_0000, 32'h7FFF_FFFF});
    check_eq("issue2_mvm_valid", mvm_valid, 1);
    @(posedge clk); #1;

    // J frame with s_last on beat 5
    fe0 = fe_cnt;
    for (int e = 0; e < 5; e++) begin
      exp_j[e*DW +: DW] = 32'h100 + e;
      send_beat(32'h100 + e, 1'b0, e == 4);
      if (e == 0) check_eq("j_reload_clears", j_loaded, 0);
    end
    check_eq("early_fe", frame_err, 1);
    check_eq("early_state", state_dbg, ST_IDLE);
    check_eq("early_j_loaded", j_loaded, 0);
    @(posedge clk); #1;
    check_eq("early_fe_pulse", frame_err, 0);
    check_eq("early_j_out", j_out, exp_j);
    send_x_frame({32'd12, 32'd11, 32'd10, 32'd9});
    check_eq("early_x_no_mvm", mvm_valid, 0);
    check_eq("early_x_out", x_out, exp_x);
    check_eq("early_fe_count", fe_cnt - fe0, 1);

    // reload J, then x frame missing s_last and drained
    send_j_frame(1'b0, 32'h200);
    check_eq("reload_j_loaded", j_loaded, 1);
    fe0 = fe_cnt;
    for (int k = 0; k < N; k++) begin
      exp_x[k*DW +: DW] = 32'h40 + k;
      send_beat(32'h40 + k, 1'b1, 1'b0);
    end
    check_eq("miss_fe", frame_err, 1);
    check_eq("miss_state", state_dbg, ST_DRAIN);
    send_beat(32'hDEAD_0000, 1'b1, 1'b0);
    send_beat(32'hBEEF_0000, 1'b1, 1'b1);
    check_eq("drain_state", state_dbg, ST_IDLE);
    check_eq("drain_x_out", x_out, exp_x);
    check_eq("drain_j_loaded", j_loaded, 1);
    check_eq("drain_fe_count", fe_cnt - fe0, 1);
    check_eq("drain_mvm", mvm_valid, 0);

    // reset in the middle of a J frame
    for (int e = 0; e < 7; e++) send_beat(32'h300 + e, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    exp_j = '0; exp_x = '0;
    check_eq("midrst_j_out", j_out, 0);
    check_eq("midrst_x_out", x_out, 0);
    check_eq("midrst_flags", {mvm_valid, j_loaded, frame_err, s_ready}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("midrst_state", state_dbg, ST_IDLE);
    send_j_frame(1'b1, '0);
    check_eq("midrst_j_loaded", j_loaded, 1);
    check_eq("midrst_j_out", j_out, exp_j);
    exp_q.push_back({32'd3, 32'd2, 32'd1, 32'd0});
    send_x_frame({32'd3, 32'd2, 32'd1, 32'd0});
    check_eq("midrst_issue", mvm_valid, 1);
    repeat (3) @(posedge clk);
    #1;
    check_eq("exp_q_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
